jtag_tap_param: RTL and testbench

//  Parametrised IEEE 1149.1 TAP: 16-state controller, IR_WIDTH instruction reg, BYPASS, IDCODE,
//  BSR_LEN-cell boundary-scan register (SAMPLE/PRELOAD, EXTEST), optional NUM_USER user DR channels.

---
 rtl/jtag_pkg.sv | 68 ++++++
 rtl/jtag_tap_fsm.sv | 65 ++++++
 rtl/jtag_tap_param.sv | 216 +++++++++++++++++++++
 tb/tb_jtag_tap_param.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and helpers for the parametrised JTAG TAP.
//  - tap_state_e : 4-bit encoding of the 16 TAP controller states
//  - instr_e     : decoded instruction class
//  - OPC_*       : base opcode values; the top sizes them to IR_WIDTH
//  - user_opcode : USERk opcode for a given IR width (MSB set, k in the low bits)
//  - tap_next    : TAP next-state function (tms sampled on posedge tck)
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [2:0] {
    INS_EXTEST,
    INS_IDCODE,
    INS_SAMPLE,
    INS_BYPASS,
    INS_USER
  } instr_e;

  localparam int OPC_EXTEST = 0;
  localparam int OPC_IDCODE = 1;
  localparam int OPC_SAMPLE = 2;

  function automatic logic [31:0] user_opcode(input int k, input int ir_w);
    return (32'd1 << (ir_w - 1)) | 32'(k);
  endfunction

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state IEEE 1149.1 TAP controller.
// Ports:
//   tck_i, trst_ni  test clock, async active-low reset (-> Test-Logic-Reset)
//   tms_i           mode select, sampled on posedge tck
//   state_o         current state
//   tlr_o           in Test-Logic-Reset
//   capture/shift/update_{ir,dr}_o  one-hot strobes, high while in that state;
//                   the datapath acts on the posedge that leaves the state.
//
// state     | meaning
// TLR       | test logic reset, IR forced to IDCODE
// RTI       | run-test/idle
// SEL_DR/IR | scan selection
// CAP_DR/IR | parallel load of the shift register
// SHIFT_*   | serial shift tdi -> tdo
// EXIT1/2_* | leave shift / pause
// PAUSE_*   | hold shift register
// UPD_DR/IR | latch shift register into update stage
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       tlr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TAP_TLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = tap_next(state_q, tms_i);
    tlr_o        = 1'b0;
    capture_ir_o = 1'b0;
    shift_ir_o   = 1'b0;
    update_ir_o  = 1'b0;
    capture_dr_o = 1'b0;
    shift_dr_o   = 1'b0;
    update_dr_o  = 1'b0;
    case (state_q)
      TAP_TLR:      tlr_o        = 1'b1;
      TAP_CAP_IR:   capture_ir_o = 1'b1;
      TAP_SHIFT_IR: shift_ir_o   = 1'b1;
      TAP_UPD_IR:   update_ir_o  = 1'b1;
      TAP_CAP_DR:   capture_dr_o = 1'b1;
      TAP_SHIFT_DR: shift_dr_o   = 1'b1;
      TAP_UPD_DR:   update_dr_o  = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised JTAG TAP with BYPASS, IDCODE, boundary-scan
// (SAMPLE/PRELOAD, EXTEST) and optional user DR channels.
// Optional feature macro: JTAG_USER_DR_EN (user DRs, USERk opcodes, user_* ports).
// Ports:
//   tck, trst (async active-low), tms, tdi   pad-side JTAG inputs
//   tdo, tdo_oe                              serial out, registered on negedge tck
//   tap_state                                current TAP state (debug)
//   bsr_in / bsr_out                         boundary-scan capture / update latches
//   extest_mode                              EXTEST is the active instruction
//   user_in / user_out / user_upd            user DR capture, update latches, update pulse
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          BSR_LEN    = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h2B5A_C001,
  parameter int          NUM_USER   = 2,
  parameter int          USER_W     = 8
) (
  input  logic                         tck,
  input  logic                         trst,
  input  logic                         tms,
  input  logic                         tdi,
  output logic                         tdo,
  output logic                         tdo_oe,
  output logic [3:0]                   tap_state,
  input  logic [BSR_LEN-1:0]           bsr_in,
  output logic [BSR_LEN-1:0]           bsr_out,
  output logic                         extest_mode,
  input  logic [NUM_USER*USER_W-1:0]   user_in,
  output logic [NUM_USER*USER_W-1:0]   user_out,
  output logic [NUM_USER-1:0]          user_upd
);

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OPC_EXTEST);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OPC_SAMPLE);

  tap_state_e state;
  logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_fsm (
    .tck_i        (tck),
    .trst_ni      (trst),
    .tms_i        (tms),
    .state_o      (state),
    .tlr_o        (tlr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr)
  );

  assign tap_state = state;

  // Instruction register: shift stage plus active IR.
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d, ir_q, ir_d;
  instr_e              instr;
  logic                user_hit;
  logic                user_tdo;

  always_comb begin
    ir_sh_d = ir_sh_q;
    if (capture_ir)    ir_sh_d = IR_WIDTH'(1);
    else if (shift_ir) ir_sh_d = {tdi, ir_sh_q[IR_WIDTH-1:1]};
    ir_d = ir_q;
    if (tlr)            ir_d = OP_IDCODE;
    else if (update_ir) ir_d = ir_sh_q;
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sh_q <= IR_WIDTH'(1);
      ir_q    <= OP_IDCODE;
    end else begin
      ir_sh_q <= ir_sh_d;
      ir_q    <= ir_d;
    end
  end

  // Anything that is not a listed opcode (or an enabled USERk) is BYPASS.
  always_comb begin
    instr = INS_BYPASS;
    if (ir_q == OP_EXTEST)      instr = INS_EXTEST;
    else if (ir_q == OP_IDCODE) instr = INS_IDCODE;
    else if (ir_q == OP_SAMPLE) instr = INS_SAMPLE;
    else if (user_hit)          instr = INS_USER;
  end

  assign extest_mode = (instr == INS_EXTEST);

  // Fixed data registers.
  logic               bypass_q, bypass_d;
  logic [31:0]        idcode_q, idcode_d;
  logic [BSR_LEN-1:0] bsr_sh_q, bsr_sh_d, bsr_out_q, bsr_out_d;
  logic               bsr_sel;

  assign bsr_sel = (instr == INS_SAMPLE) || (instr == INS_EXTEST);

  always_comb begin
    bypass_d  = bypass_q;
    idcode_d  = idcode_q;
    bsr_sh_d  = bsr_sh_q;
    bsr_out_d = bsr_out_q;
    if (capture_dr) begin
      if (instr == INS_BYPASS) bypass_d = 1'b0;
      if (instr == INS_IDCODE) idcode_d = IDCODE_VAL;
      if (bsr_sel)             bsr_sh_d = bsr_in;
    end else if (shift_dr) begin
      if (instr == INS_BYPASS) bypass_d = tdi;
      if (instr == INS_IDCODE) idcode_d = {tdi, idcode_q[31:1]};
      if (bsr_sel)             bsr_sh_d = {tdi, bsr_sh_q[BSR_LEN-1:1]};
    end
    if (update_dr && bsr_sel) bsr_out_d = bsr_sh_q;
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_q  <= 1'b0;
      idcode_q  <= IDCODE_VAL;
      bsr_sh_q  <= '0;
      bsr_out_q <= '0;
    end else begin
      bypass_q  <= bypass_d;
      idcode_q  <= idcode_d;
      bsr_sh_q  <= bsr_sh_d;
      bsr_out_q <= bsr_out_d;
    end
  end

  assign bsr_out = bsr_out_q;

`ifdef JTAG_USER_DR_EN
  logic [NUM_USER-1:0]             user_sel;
  logic [NUM_USER-1:0][USER_W-1:0] user_sh_q, user_sh_d, user_out_q, user_out_d;
  logic [NUM_USER-1:0]             user_upd_q, user_upd_d;

  always_comb begin
    user_sel = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      if (ir_q == IR_WIDTH'(user_opcode(k, IR_WIDTH))) user_sel[k] = 1'b1;
    end
  end

  assign user_hit = |user_sel;

  // The update pulse is registered so it lines up with the new user_out value.
  always_comb begin
    user_sh_d  = user_sh_q;
    user_out_d = user_out_q;
    user_upd_d = '0;
    user_tdo   = 1'b0;
    for (int k = 0; k < NUM_USER; k++) begin
      if (user_sel[k]) begin
        user_tdo = user_sh_q[k][0];
        if (capture_dr)    user_sh_d[k] = user_in[k*USER_W +: USER_W];
        else if (shift_dr) user_sh_d[k] = {tdi, user_sh_q[k][USER_W-1:1]};
        if (update_dr) begin
          user_out_d[k] = user_sh_q[k];
          user_upd_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      user_sh_q  <= '0;
      user_out_q <= '0;
      user_upd_q <= '0;
    end else begin
      user_sh_q  <= user_sh_d;
      user_out_q <= user_out_d;
      user_upd_q <= user_upd_d;
    end
  end

  assign user_out = user_out_q;
  assign user_upd = user_upd_q;
`else
  logic unused_user_in;
  assign unused_user_in = ^user_in;
  assign user_hit = 1'b0;
  assign user_tdo = 1'b0;
  assign user_out = '0;
  assign user_upd = '0;
`endif

  logic dr_tdo;
  always_comb begin
    case (instr)
      INS_IDCODE:             dr_tdo = idcode_q[0];
      INS_SAMPLE, INS_EXTEST: dr_tdo = bsr_sh_q[0];
      INS_USER:               dr_tdo = user_tdo;
      default:                dr_tdo = bypass_q;
    endcase
  end

  // Negedge launch from the posedge state: a bit shifted at posedge n is on tdo at negedge n.
  logic tdo_q, tdo_oe_q;
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_oe_q <= shift_ir | shift_dr;
      tdo_q    <= shift_ir ? ir_sh_q[0] : (shift_dr ? dr_tdo : 1'b0);
    end
  end

  assign tdo    = tdo_q;
  assign tdo_oe = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
module tb_jtag_tap_param;

  logic        tck = 1'b0;
  logic        trst = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo, tdo_oe, extest_mode;
  logic [3:0]  tap_state;
  logic [7:0]  bsr_in = 8'h00;
  logic [7:0]  bsr_out;
  logic [15:0] user_in = 16'h0000;
  logic [15:0] user_out;
  logic [1:0]  user_upd;

  int n_cmp = 0;
  int n_err = 0;

  jtag_tap_param dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .tap_state(tap_state), .bsr_in(bsr_in), .bsr_out(bsr_out),
    .extest_mode(extest_mode), .user_in(user_in), .user_out(user_out),
    .user_upd(user_upd)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tck: drive, let the posedge act, sample after the negedge.
  task automatic tick(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RTI: IR scan of op; returns captured IR bits and extest_mode seen in Update-IR.
  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap, output logic ext_pre);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo;
      tick(i == 3, op[i]);
    end
    tick(1, 0);
    ext_pre = extest_mode;
    tick(0, 0);
  endtask

  // From RTI: DR scan of n bits, ends in RTI one tck after Update-DR.
  task automatic scan_dr(input logic [31:0] din, input int n, input string tag,
                         output logic [31:0] dout);
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk({tag, "_oe_shift"}, 64'(tdo_oe), 64'd1);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0);
    tick(0, 0);
  endtask

  logic [31:0] dout;
  logic [3:0]  cap;
  logic        ext_pre;

  initial begin
    // reset state
    #12;
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_tdo", 64'(tdo), 64'd0);
    chk("rst_tdo_oe", 64'(tdo_oe), 64'd0);
    chk("rst_bsr_out", 64'(bsr_out), 64'h00);
    chk("rst_extest", 64'(extest_mode), 64'd0);
    chk("rst_user_out", 64'(user_out), 64'h0);
    chk("rst_user_upd", 64'(user_upd), 64'h0);
    @(negedge tck); #1;
    trst = 1'b1;

    // IDCODE readout straight out of reset
    tick(0, 0);
    chk("rti_state", 64'(tap_state), 64'hC);
    scan_dr(32'h0, 32, "idcode0", dout);
    chk("idcode0", 64'(dout), 64'h2B5A_C001);
    chk("idle_oe", 64'(tdo_oe), 64'd0);
    chk("idle_tdo", 64'(tdo), 64'd0);

    // IDCODE with a pause in the middle: no recapture on resume
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      dout[i] = tdo;
      tick(i == 3, 1'b0);
    end
    tick(0, 0); tick(0, 0);
    chk("pause_dr_state", 64'(tap_state), 64'h3);
    chk("pause_dr_oe", 64'(tdo_oe), 64'd0);
    tick(1, 0); tick(0, 0);
    for (int i = 4; i < 32; i++) begin
      dout[i] = tdo;
      tick(i == 31, 1'b0);
    end
    tick(1, 0); tick(0, 0);
    chk("idcode_pause", 64'(dout), 64'h2B5A_C001);

    // BYPASS: IR capture pattern and one-cycle delay
    load_ir(4'hF, cap, ext_pre);
    chk("ir_capture", 64'(cap), 64'h1);
    scan_dr(32'b1101, 4, "bypass", dout);
    chk("bypass_stream", 64'(dout[3:0]), 64'hA);

    // five tms=1 from Shift-IR reach TLR and restore IDCODE
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("shift_ir_state", 64'(tap_state), 64'hA);
    chk("shift_ir_oe", 64'(tdo_oe), 64'd1);
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tms5_tlr", 64'(tap_state), 64'hF);
    tick(0, 0);
    scan_dr(32'h0, 32, "idcode1", dout);
    chk("idcode_after_tlr", 64'(dout), 64'h2B5A_C001);

    // SAMPLE
    bsr_in = 8'hA5;
    load_ir(4'h2, cap, ext_pre);
    chk("sample_extest", 64'(extest_mode), 64'd0);
    scan_dr(32'h3C, 8, "sample", dout);
    chk("sample_stream", 64'(dout[7:0]), 64'hA5);
    chk("sample_bsr_out", 64'(bsr_out), 64'h3C);
    chk("sample_extest2", 64'(extest_mode), 64'd0);
    chk("sample_no_upd", 64'(user_upd), 64'h0);

    // EXTEST: active only after Update-IR
    bsr_in = 8'h96;
    load_ir(4'h0, cap, ext_pre);
    chk("extest_pre", 64'(ext_pre), 64'd0);
    chk("extest_on", 64'(extest_mode), 64'd1);
    scan_dr(32'h69, 8, "extest", dout);
    chk("extest_stream", 64'(dout[7:0]), 64'h96);
    chk("extest_bsr_out", 64'(bsr_out), 64'h69);

    // unlisted opcode acts as BYPASS, BSR latches untouched
    load_ir(4'h7, cap, ext_pre);
    chk("op7_extest", 64'(extest_mode), 64'd0);
    scan_dr(32'b1101, 4, "op7", dout);
    chk("op7_stream", 64'(dout[3:0]), 64'hA);
    chk("op7_bsr_hold", 64'(bsr_out), 64'h69);

`ifdef JTAG_USER_DR_EN
    user_in = {8'h5A, 8'h11};
    load_ir(4'h9, cap, ext_pre);
    scan_dr(32'hC3, 8, "user1", dout);
    chk("user1_stream", 64'(dout[7:0]), 64'h5A);
    chk("user1_out", 64'(user_out), 64'hC300);
    chk("user1_upd", 64'(user_upd), 64'h2);
    tick(0, 0);
    chk("user1_upd_end", 64'(user_upd), 64'h0);
    // trst during Shift-DR of USER1
    user_in = {8'h77, 8'h11};
    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 0);
    #2 trst = 1'b0;
    #1;
    chk("trst_user_out", 64'(user_out), 64'h0);
    chk("trst_user_upd", 64'(user_upd), 64'h0);
    chk("trst_state", 64'(tap_state), 64'hF);
    @(negedge tck); #1;
    trst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1, 0);
    chk("trst_no_pulse", 64'(user_upd), 64'h0);
    tick(0, 0);
`else
    user_in = {8'h5A, 8'h11};
    load_ir(4'h9, cap, ext_pre);
    scan_dr(32'b1101, 4, "user1_off", dout);
    chk("user1_off_stream", 64'(dout[3:0]), 64'hA);
    chk("user1_off_out", 64'(user_out), 64'h0);
    chk("user1_off_upd", 64'(user_upd), 64'h0);
`endif

    // trst mid SAMPLE shift: latches cleared, no update
    load_ir(4'h2, cap, ext_pre);
    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 1);
    #2 trst = 1'b0;
    #1;
    chk("trst_bsr_out", 64'(bsr_out), 64'h00);
    chk("trst_tdo_oe", 64'(tdo_oe), 64'd0);
    @(negedge tck); #1;
    trst = 1'b1;
    tick(0, 0);
    scan_dr(32'h0, 32, "idcode2", dout);
    chk("idcode_after_trst", 64'(dout), 64'h2B5A_C001);
    chk("bsr_after_trst", 64'(bsr_out), 64'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
